// File: rtl/pengo_rom_loader.sv
// Start-up sequencer and single-port RAM arbiter between the MiST download stream and the CPU.
// Define PENGO_ROM_CHECKSUM_EN to add the checksum / checksum_ok outputs.
module pengo_rom_loader #(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] ROM_INDEX   = 8'd0,
  parameter logic [7:0] PATCH_INDEX = 8'd1,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_downl,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [23:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_dout,
  output logic              cpu_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
`ifdef PENGO_ROM_CHECKSUM_EN
  output logic [7:0]        checksum,
  output logic              checksum_ok,
`endif
  output logic              machine_reset
);

  typedef enum logic [1:0] {HOLD, RUN, LOAD, PATCH} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t            state;
  logic [7:0]        hold_cnt;
  logic              downl_d;
  logic              dl_rise;
  logic              dl_fall;
  logic              load_enter;
  logic              in_range;
  logic              cpu_go;
  logic              load_wr;
  logic              patch_cap;
  logic              commit;
  logic              load_we;
  logic              buf_full;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_p1;

  assign dl_rise    = ioctl_downl & ~downl_d;
  assign dl_fall    = ~ioctl_downl & downl_d;
  assign load_enter = dl_rise && (ioctl_index == ROM_INDEX) && (state == HOLD || state == RUN);
  assign in_range   = ((ioctl_addr >> ADDR_W) == 24'd0);
  assign cpu_go     = cpu_rd && (state == RUN || state == PATCH);
  assign load_wr    = ioctl_wr && in_range && (state == LOAD);
  assign patch_cap  = ioctl_wr && in_range && (state == PATCH);

  // The patch buffer only holds data while in PATCH; a CPU read always takes the port first.
  assign commit     = buf_full & ~cpu_go;
  assign mem_addr   = cpu_go ? cpu_addr : wr_addr;
  assign mem_din    = wr_data;
  assign mem_we     = load_we | commit;
  assign ioctl_wait = buf_full;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= HOLD;
      hold_cnt      <= 8'd0;
      machine_reset <= 1'b1;
      downl_d       <= 1'b0;
    end else begin
      downl_d <= ioctl_downl;
      case (state)
        HOLD: begin
          if (load_enter) begin
            state    <= LOAD;
            hold_cnt <= 8'd0;
          end else if (hold_cnt == HOLD_LAST) begin
            state         <= RUN;
            machine_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          if (load_enter) begin
            state         <= LOAD;
            machine_reset <= 1'b1;
          end else if (dl_rise && ioctl_index == PATCH_INDEX) begin
            state <= PATCH;
          end
        end
        LOAD: begin
          if (dl_fall) begin
            state    <= HOLD;
            hold_cnt <= 8'd0;
          end
        end
        PATCH: begin
          // Leave only once the download has ended and nothing is left to commit.
          if (!ioctl_downl && !buf_full && !patch_cap) begin
            state <= RUN;
          end
        end
        default: begin
          state         <= HOLD;
          hold_cnt      <= 8'd0;
          machine_reset <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      load_we   <= 1'b0;
      buf_full  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      rd_p1     <= 1'b0;
      cpu_valid <= 1'b0;
      cpu_dout  <= 8'd0;
    end else begin
      load_we   <= load_wr;
      rd_p1     <= cpu_go;
      cpu_valid <= rd_p1;
      if (rd_p1) begin
        cpu_dout <= mem_dout;
      end
      if (load_wr || patch_cap) begin
        wr_addr <= ioctl_addr[ADDR_W-1:0];
        wr_data <= ioctl_dout;
      end
      // A new capture wins over a same-cycle commit so the fresh byte is never lost.
      if (patch_cap) begin
        buf_full <= 1'b1;
      end else if (commit) begin
        buf_full <= 1'b0;
      end
    end
  end

`ifdef PENGO_ROM_CHECKSUM_EN
  logic [7:0] csum_next;

  assign csum_next = checksum + (load_wr ? ioctl_dout : 8'd0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      checksum    <= 8'd0;
      checksum_ok <= 1'b0;
    end else if (load_enter) begin
      checksum    <= 8'd0;
      checksum_ok <= 1'b0;
    end else begin
      if (load_wr) begin
        checksum <= csum_next;
      end
      // csum_next already includes a byte strobed on the final cycle of the load.
      if (state == LOAD && dl_fall) begin
        checksum_ok <= (csum_next == 8'h00);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pengo_rom_loader.sv
// Directed bench for pengo_rom_loader driving a behavioural 1-cycle-latency synchronous RAM.
module tb_pengo_rom_loader;
  localparam int ADDR_W = 16;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_downl = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic              ioctl_wr = 1'b0;
  logic [23:0]       ioctl_addr = 24'd0;
  logic [7:0]        ioctl_dout = 8'd0;
  logic              ioctl_wait;
  logic              cpu_rd = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_dout;
  logic              cpu_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout = 8'd0;
  logic              machine_reset;
`ifdef PENGO_ROM_CHECKSUM_EN
  logic [7:0]        checksum;
  logic              checksum_ok;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [0:65535];

  pengo_rom_loader #(.ADDR_W(ADDR_W), .ROM_INDEX(8'd0), .PATCH_INDEX(8'd1), .HOLD_CYCLES(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_valid(cpu_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
`ifdef PENGO_ROM_CHECKSUM_EN
    .checksum(checksum), .checksum_ok(checksum_ok),
`endif
    .machine_reset(machine_reset)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
  end

  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    smp();
    checks++; if (machine_reset !== 1'b1) begin errors++; $display("[TB] FAIL rst_machine_reset: got %b expected 1", machine_reset); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL rst_ioctl_wait: got %b expected 0", ioctl_wait); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we: got %b expected 0", mem_we); end
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_cpu_valid: got %b expected 0", cpu_valid); end
    checks++; if (cpu_dout !== 8'h00) begin errors++; $display("[TB] FAIL rst_cpu_dout: got %h expected 00", cpu_dout); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin errors++; $display("[TB] FAIL rst_mem_din: got %h expected 00", mem_din); end
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc(); smp();
      checks++; if (machine_reset !== (k < 16)) begin errors++; $display("[TB] FAIL rst_hold_len k=%0d: got %b expected %b", k, machine_reset, (k < 16)); end
    end
  endtask

  task automatic test_load();
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc(); ioctl_index = 8'd0; ioctl_downl = 1'b1; smp();
    checks++; if (machine_reset !== 1'b0) begin errors++; $display("[TB] FAIL load_pre_mr: got %b expected 0", machine_reset); end
    for (int i = 0; i < 4; i++) begin
      cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'(i); ioctl_dout = bytes[i]; smp();
      if (i == 0) begin
        checks++; if (machine_reset !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL load_entry: got mr=%b we=%b expected mr=1 we=0", machine_reset, mem_we); end
      end else begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'(i - 1) || mem_din !== bytes[i-1]) begin errors++; $display("[TB] FAIL load_write%0d: got we=%b addr=%h din=%h expected we=1 addr=%h din=%h", i - 1, mem_we, mem_addr, mem_din, 16'(i - 1), bytes[i-1]); end
      end
    end
    cyc(); ioctl_wr = 1'b0; ioctl_downl = 1'b0; smp();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0003 || mem_din !== 8'h44) begin errors++; $display("[TB] FAIL load_write3: got we=%b addr=%h din=%h expected we=1 addr=0003 din=44", mem_we, mem_addr, mem_din); end
    cyc(); smp();
    checks++; if (mem_we !== 1'b0 || machine_reset !== 1'b1) begin errors++; $display("[TB] FAIL load_exit: got we=%b mr=%b expected we=0 mr=1", mem_we, machine_reset); end
    for (int k = 1; k <= 16; k++) begin
      cyc(); smp();
      checks++; if (machine_reset !== (k < 16)) begin errors++; $display("[TB] FAIL load_hold_len k=%0d: got %b expected %b", k, machine_reset, (k < 16)); end
    end
  endtask

  task automatic test_read();
    cyc(); cpu_rd = 1'b1; cpu_addr = 16'h0002; smp();
    checks++; if (mem_addr !== 16'h0002 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL read_port: got addr=%h we=%b expected addr=0002 we=0", mem_addr, mem_we); end
    cyc(); cpu_rd = 1'b0; smp();
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("[TB] FAIL read_early: got valid=%b expected 0", cpu_valid); end
    cyc(); smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h33) begin errors++; $display("[TB] FAIL read_data: got valid=%b dout=%h expected valid=1 dout=33", cpu_valid, cpu_dout); end
    cyc(); smp();
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("[TB] FAIL read_pulse: got valid=%b expected 0", cpu_valid); end
  endtask

  task automatic test_back_to_back();
    cyc(); cpu_rd = 1'b1; cpu_addr = 16'h0000; smp();
    cyc(); cpu_addr = 16'h0001; smp();
    cyc(); cpu_addr = 16'h0003; smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h11) begin errors++; $display("[TB] FAIL b2b_0: got valid=%b dout=%h expected valid=1 dout=11", cpu_valid, cpu_dout); end
    cyc(); cpu_rd = 1'b0; smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h22) begin errors++; $display("[TB] FAIL b2b_1: got valid=%b dout=%h expected valid=1 dout=22", cpu_valid, cpu_dout); end
    cyc(); smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h44) begin errors++; $display("[TB] FAIL b2b_3: got valid=%b dout=%h expected valid=1 dout=44", cpu_valid, cpu_dout); end
    cyc(); smp();
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got valid=%b expected 0", cpu_valid); end
  endtask

  task automatic test_patch();
    cyc(); ioctl_index = 8'd1; ioctl_downl = 1'b1; smp();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'h000010; ioctl_dout = 8'hA5; cpu_rd = 1'b1; cpu_addr = 16'h0000; smp();
    checks++; if (machine_reset !== 1'b0 || mem_addr !== 16'h0000 || mem_we !== 1'b0 || ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL patch_capture: got mr=%b addr=%h we=%b wait=%b expected mr=0 addr=0000 we=0 wait=0", machine_reset, mem_addr, mem_we, ioctl_wait); end
    cyc(); ioctl_wr = 1'b0; cpu_addr = 16'h0001; smp();
    checks++; if (ioctl_wait !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0001 || machine_reset !== 1'b0) begin errors++; $display("[TB] FAIL patch_slip: got wait=%b we=%b addr=%h mr=%b expected wait=1 we=0 addr=0001 mr=0", ioctl_wait, mem_we, mem_addr, machine_reset); end
    cyc(); cpu_rd = 1'b0; smp();
    checks++; if (ioctl_wait !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_din !== 8'hA5) begin errors++; $display("[TB] FAIL patch_commit: got wait=%b we=%b addr=%h din=%h expected wait=1 we=1 addr=0010 din=a5", ioctl_wait, mem_we, mem_addr, mem_din); end
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h11) begin errors++; $display("[TB] FAIL patch_read0: got valid=%b dout=%h expected valid=1 dout=11", cpu_valid, cpu_dout); end
    cyc(); smp();
    checks++; if (ioctl_wait !== 1'b0 || mem_we !== 1'b0 || machine_reset !== 1'b0) begin errors++; $display("[TB] FAIL patch_empty: got wait=%b we=%b mr=%b expected wait=0 we=0 mr=0", ioctl_wait, mem_we, machine_reset); end
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h22) begin errors++; $display("[TB] FAIL patch_read1: got valid=%b dout=%h expected valid=1 dout=22", cpu_valid, cpu_dout); end
    cyc(); ioctl_downl = 1'b0; smp();
    cyc(); smp();
    checks++; if (machine_reset !== 1'b0) begin errors++; $display("[TB] FAIL patch_exit_mr: got %b expected 0", machine_reset); end
    cyc(); cpu_rd = 1'b1; cpu_addr = 16'h0010; smp();
    cyc(); cpu_rd = 1'b0; smp();
    cyc(); smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'hA5) begin errors++; $display("[TB] FAIL patch_readback: got valid=%b dout=%h expected valid=1 dout=a5", cpu_valid, cpu_dout); end
  endtask

  task automatic test_ignored();
    cyc(); ioctl_index = 8'd5; ioctl_downl = 1'b1; smp();
    for (int i = 0; i < 3; i++) begin
      cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'h000020 + 24'(i); ioctl_dout = 8'h5A; smp();
      checks++; if (mem_we !== 1'b0 || machine_reset !== 1'b0 || ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL idx5_write%0d: got we=%b mr=%b wait=%b expected we=0 mr=0 wait=0", i, mem_we, machine_reset, ioctl_wait); end
    end
    cyc(); ioctl_wr = 1'b0; ioctl_downl = 1'b0; smp();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL idx5_tail: got we=%b expected 0", mem_we); end
    cyc(); ioctl_index = 8'd1; ioctl_downl = 1'b1; smp();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'h010000; ioctl_dout = 8'h77; smp();
    cyc(); ioctl_wr = 1'b0; smp();
    checks++; if (mem_we !== 1'b0 || ioctl_wait !== 1'b0 || machine_reset !== 1'b0) begin errors++; $display("[TB] FAIL oor_write: got we=%b wait=%b mr=%b expected we=0 wait=0 mr=0", mem_we, ioctl_wait, machine_reset); end
    cyc(); ioctl_downl = 1'b0; smp();
    cyc(); smp();
    cyc(); cpu_rd = 1'b1; cpu_addr = 16'h0020; smp();
    cyc(); cpu_addr = 16'h0000; smp();
    cyc(); cpu_rd = 1'b0; smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h00) begin errors++; $display("[TB] FAIL idx5_ram: got valid=%b dout=%h expected valid=1 dout=00", cpu_valid, cpu_dout); end
    cyc(); smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'h11) begin errors++; $display("[TB] FAIL oor_alias: got valid=%b dout=%h expected valid=1 dout=11", cpu_valid, cpu_dout); end
  endtask

  task automatic test_reset_mid_load();
    cyc(); smp();
    #1 reset = 1'b1;
    #1;
    checks++; if (machine_reset !== 1'b1) begin errors++; $display("[TB] FAIL async_mr: got %b expected 1", machine_reset); end
    cyc(); cyc(); reset = 1'b0; ioctl_index = 8'd0; ioctl_downl = 1'b1; smp();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'h000006; ioctl_dout = 8'h99; smp();
    checks++; if (machine_reset !== 1'b1) begin errors++; $display("[TB] FAIL hold_to_load: got mr=%b expected 1", machine_reset); end
    cyc(); ioctl_wr = 1'b0; smp();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0006) begin errors++; $display("[TB] FAIL midload_pending: got we=%b addr=%h expected we=1 addr=0006", mem_we, mem_addr); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || machine_reset !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL midload_async: got we=%b mr=%b addr=%h expected we=0 mr=1 addr=0000", mem_we, machine_reset, mem_addr); end
    cyc(); ioctl_downl = 1'b0;
    cyc(); reset = 1'b0; smp();
    cyc(); ioctl_downl = 1'b1; smp();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'h000005; ioctl_dout = 8'hC3; ioctl_downl = 1'b0; smp();
    checks++; if (machine_reset !== 1'b1) begin errors++; $display("[TB] FAIL fresh_load_mr: got %b expected 1", machine_reset); end
    cyc(); ioctl_wr = 1'b0; smp();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0005 || mem_din !== 8'hC3) begin errors++; $display("[TB] FAIL fresh_last_write: got we=%b addr=%h din=%h expected we=1 addr=0005 din=c3", mem_we, mem_addr, mem_din); end
    for (int k = 1; k <= 16; k++) begin
      cyc(); smp();
      checks++; if (machine_reset !== (k < 16)) begin errors++; $display("[TB] FAIL fresh_hold_len k=%0d: got %b expected %b", k, machine_reset, (k < 16)); end
    end
    cyc(); cpu_rd = 1'b1; cpu_addr = 16'h0005; smp();
    cyc(); cpu_rd = 1'b0; smp();
    cyc(); smp();
    checks++; if (cpu_valid !== 1'b1 || cpu_dout !== 8'hC3) begin errors++; $display("[TB] FAIL fresh_readback: got valid=%b dout=%h expected valid=1 dout=c3", cpu_valid, cpu_dout); end
  endtask

`ifdef PENGO_ROM_CHECKSUM_EN
  task automatic test_checksum();
    cyc(); ioctl_index = 8'd0; ioctl_downl = 1'b1; smp();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'h000000; ioctl_dout = 8'h80; smp();
    cyc(); ioctl_addr = 24'h000001; smp();
    cyc(); ioctl_wr = 1'b0; ioctl_downl = 1'b0; smp();
    cyc(); smp();
    checks++; if (checksum !== 8'h00 || checksum_ok !== 1'b1) begin errors++; $display("[TB] FAIL csum_good: got sum=%h ok=%b expected sum=00 ok=1", checksum, checksum_ok); end
    repeat (17) cyc();
    ioctl_downl = 1'b1; smp();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 24'h000000; ioctl_dout = 8'h01; smp();
    checks++; if (checksum_ok !== 1'b0) begin errors++; $display("[TB] FAIL csum_held: got ok=%b expected 0", checksum_ok); end
    cyc(); ioctl_addr = 24'h000001; ioctl_dout = 8'h00; ioctl_downl = 1'b0; smp();
    cyc(); ioctl_wr = 1'b0; smp();
    checks++; if (checksum !== 8'h01 || checksum_ok !== 1'b0) begin errors++; $display("[TB] FAIL csum_bad: got sum=%h ok=%b expected sum=01 ok=0", checksum, checksum_ok); end
    repeat (17) cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_read();
    test_back_to_back();
    test_patch();
    test_ignored();
    test_reset_mid_load();
`ifdef PENGO_ROM_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
